// File: rtl/mips_load_pkg.sv
// Shared encodings for the MIPS I load/writeback slice: load kinds,
// writeback FSM states and register-file byte-enable constants.
package mips_load_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LWL = 3'd2,
    LD_LW  = 3'd3,
    LD_LBU = 3'd4,
    LD_LHU = 3'd5,
    LD_LWR = 3'd6
  } ld_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [3:0] WE_ALL  = 4'b1111;
  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/mips_load_align.sv
// Combinational load aligner: selects the addressed byte/halfword lane,
// extends it, and builds the LWL/LWR partial-word merge with byte enables.
module mips_load_align
  import mips_load_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [3:0]  we_o,
  output logic [31:0] d_o
);

  logic [1:0]  lane;
  logic        half_sel;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Big-endian puts byte address 0 in the top lane, so the lane index is 3-a.
  assign lane     = BIG_ENDIAN ? ~addr_i : addr_i;
  assign half_sel = BIG_ENDIAN ? ~addr_i[1] : addr_i[1];
  assign byte_v   = data_i[{lane, 3'b000} +: 8];
  assign half_v   = half_sel ? data_i[31:16] : data_i[15:0];

  always_comb begin
    we_o = WE_ALL;
    d_o  = data_i;
    case (op_i)
      LD_LB:  d_o = {{24{byte_v[7]}}, byte_v};
      LD_LBU: d_o = {24'd0, byte_v};
      LD_LH:  d_o = {{16{half_v[15]}}, half_v};
      LD_LHU: d_o = {16'd0, half_v};
      // Partial-word loads only enable the lanes they replace; the register
      // file keeps the remaining bytes, so no read-modify-write is needed.
      LD_LWL: begin
        d_o  = data_i << {~lane, 3'b000};
        we_o = WE_ALL << ~lane;
      end
      LD_LWR: begin
        d_o  = data_i >> {lane, 3'b000};
        we_o = WE_ALL >> lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_load_wb.sv
// Writeback stage feeding the register-file write port: merges ALU results
// with aligned load data (load wins) and tracks one outstanding load.
//
// state   | meaning
// IDLE    | no load outstanding, ld_ready high
// WAIT    | load accepted, waiting for its mem_valid beat
module mips_load_wb
  import mips_load_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_d,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_op,
  input  logic [4:0]  ld_rd,
  input  logic [1:0]  ld_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic        load_busy,
  output logic [4:0]  load_rd,
  output logic [4:0]  rd,
  output logic [3:0]  we,
  output logic [31:0] D
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  ldrd_q, ldrd_d;
  logic [1:0]  addr_q, addr_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] d_q, d_d;

  logic        load_wb;
  logic [3:0]  al_we;
  logic [31:0] al_d;

  mips_load_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .op_i  (op_q),
    .addr_i(addr_q),
    .data_i(mem_data),
    .we_o  (al_we),
    .d_o   (al_d)
  );

  assign load_wb   = (state_q == ST_WAIT) && mem_valid;
  assign ld_ready  = (state_q == ST_IDLE);
  assign load_busy = (state_q == ST_WAIT);
  assign alu_ready = !load_wb;
  assign load_rd   = ldrd_q;
  assign rd        = rd_q;
  assign we        = we_q;
  assign D         = d_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      ldrd_q  <= 5'd0;
      addr_q  <= 2'd0;
      rd_q    <= 5'd0;
      we_q    <= WE_NONE;
      d_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ldrd_q  <= ldrd_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ldrd_d  = ldrd_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    we_d    = WE_NONE;
    d_d     = d_q;

    case (state_q)
      ST_IDLE: begin
        if (ld_valid) begin
          state_d = ST_WAIT;
          op_d    = ld_op;
          ldrd_d  = ld_rd;
          addr_d  = ld_addr;
        end
      end
      ST_WAIT: begin
        if (mem_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A colliding ALU result sees alu_ready low and is re-offered next cycle.
    if (load_wb) begin
      rd_d = ldrd_q;
      d_d  = al_d;
      we_d = al_we;
    end else if (alu_valid) begin
      rd_d = alu_rd;
      d_d  = alu_d;
      we_d = WE_ALL;
    end

    if (rd_d == 5'd0) we_d = WE_NONE;
  end

endmodule

// File: tb/tb_mips_load_wb.sv
// Bench for mips_load_wb: LE and BE instances share stimulus and are checked
// every cycle against a byte-level behavioural model of the load semantics.
module tb_mips_load_wb;
  import mips_load_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_d = '0;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_op = '0;
  logic [4:0]  ld_rd = '0;
  logic [1:0]  ld_addr = '0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;

  logic        alu_ready_le, ld_ready_le, load_busy_le;
  logic [4:0]  load_rd_le, rd_le;
  logic [3:0]  we_le;
  logic [31:0] d_le;
  logic        alu_ready_be, ld_ready_be, load_busy_be;
  logic [4:0]  load_rd_be, rd_be;
  logic [3:0]  we_be;
  logic [31:0] d_be;

  int n_checks = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mips_load_wb #(.BIG_ENDIAN(1'b0)) u_le (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready_le), .alu_rd(alu_rd), .alu_d(alu_d),
    .ld_valid(ld_valid), .ld_ready(ld_ready_le), .ld_op(ld_op), .ld_rd(ld_rd),
    .ld_addr(ld_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .load_busy(load_busy_le), .load_rd(load_rd_le), .rd(rd_le), .we(we_le), .D(d_le)
  );

  mips_load_wb #(.BIG_ENDIAN(1'b1)) u_be (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready_be), .alu_rd(alu_rd), .alu_d(alu_d),
    .ld_valid(ld_valid), .ld_ready(ld_ready_be), .ld_op(ld_op), .ld_rd(ld_rd),
    .ld_addr(ld_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .load_busy(load_busy_be), .load_rd(load_rd_be), .rd(rd_be), .we(we_be), .D(d_be)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Byte-addressed view of a load: memory byte k, register byte k (LSB first).
  function automatic void model_load(input logic [2:0] op, input logic [1:0] a,
                                     input logic [31:0] m, input bit be,
                                     output logic [3:0] w, output logic [31:0] d);
    logic [7:0]  mb[4];
    logic [7:0]  r[4];
    logic [7:0]  v;
    logic [15:0] h;
    int ai;
    int base;
    ai = int'(a);
    for (int k = 0; k < 4; k++) begin
      mb[k] = be ? m[8*(3-k) +: 8] : m[8*k +: 8];
      r[k]  = 8'h00;
    end
    w = 4'b1111;
    case (op)
      3'd0, 3'd4: begin
        v = mb[ai];
        d = (op == 3'd0) ? {{24{v[7]}}, v} : {24'h0, v};
      end
      3'd1, 3'd5: begin
        base = ai & 2;
        h = be ? {mb[base], mb[base+1]} : {mb[base+1], mb[base]};
        d = (op == 3'd1) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      3'd2: begin
        w = 4'b0000;
        if (!be) for (int k = 0; k <= ai; k++) begin r[3-k] = mb[ai-k]; w[3-k] = 1'b1; end
        else     for (int k = 0; k <= 3-ai; k++) begin r[3-k] = mb[ai+k]; w[3-k] = 1'b1; end
        d = {r[3], r[2], r[1], r[0]};
      end
      3'd6: begin
        w = 4'b0000;
        if (!be) for (int k = 0; k <= 3-ai; k++) begin r[k] = mb[ai+k]; w[k] = 1'b1; end
        else     for (int k = 0; k <= ai; k++) begin r[k] = mb[ai-k]; w[k] = 1'b1; end
        d = {r[3], r[2], r[1], r[0]};
      end
      default: d = be ? {mb[0], mb[1], mb[2], mb[3]} : {mb[3], mb[2], mb[1], mb[0]};
    endcase
  endfunction

  // Model state: one outstanding load record and the expected write port.
  bit          m_busy;
  bit          was_busy;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;
  logic [1:0]  m_addr;
  bit          e_wr;
  logic [4:0]  e_rd[2];
  logic [3:0]  e_we[2];
  logic [3:0]  e_mask[2];
  logic [31:0] e_d[2];
  logic [3:0]  tw;
  logic [31:0] td;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_rd = '0; m_op = '0; m_addr = '0; e_wr = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e_rd[i] = '0; e_we[i] = '0; e_mask[i] = '0; e_d[i] = '0;
      end
    end else begin
      was_busy = m_busy;
      e_wr = 1'b0;
      e_we[0] = 4'b0000;
      e_we[1] = 4'b0000;
      if (was_busy && mem_valid) begin
        for (int i = 0; i < 2; i++) begin
          model_load(m_op, m_addr, mem_data, i == 1, tw, td);
          e_rd[i] = m_rd; e_mask[i] = tw; e_d[i] = td;
          e_we[i] = (m_rd == 5'd0) ? 4'b0000 : tw;
        end
        e_wr = 1'b1;
        m_busy = 1'b0;
      end else if (alu_valid) begin
        for (int i = 0; i < 2; i++) begin
          e_rd[i] = alu_rd; e_mask[i] = 4'b1111; e_d[i] = alu_d;
          e_we[i] = (alu_rd == 5'd0) ? 4'b0000 : 4'b1111;
        end
        e_wr = 1'b1;
      end
      if (!was_busy && ld_valid) begin
        m_busy = 1'b1; m_op = ld_op; m_rd = ld_rd; m_addr = ld_addr;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("we_le", {28'h0, we_le}, {28'h0, e_we[0]});
      chk("we_be", {28'h0, we_be}, {28'h0, e_we[1]});
      if (e_wr) begin
        chk("rd_le", {27'h0, rd_le}, {27'h0, e_rd[0]});
        chk("rd_be", {27'h0, rd_be}, {27'h0, e_rd[1]});
        chk("D_le", d_le & lane_mask(e_mask[0]), e_d[0] & lane_mask(e_mask[0]));
        chk("D_be", d_be & lane_mask(e_mask[1]), e_d[1] & lane_mask(e_mask[1]));
      end
      chk("load_busy_le", {31'h0, load_busy_le}, {31'h0, m_busy});
      chk("load_busy_be", {31'h0, load_busy_be}, {31'h0, m_busy});
      chk("ld_ready_le", {31'h0, ld_ready_le}, {31'h0, !m_busy});
      chk("alu_ready_le", {31'h0, alu_ready_le}, {31'h0, !(m_busy && mem_valid)});
      chk("alu_ready_be", {31'h0, alu_ready_be}, {31'h0, !(m_busy && mem_valid)});
      if (m_busy) chk("load_rd_le", {27'h0, load_rd_le}, {27'h0, m_rd});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [2:0] op, input logic [4:0] r,
                         input logic [1:0] a, input logic [31:0] m);
    ld_valid = 1'b1; ld_op = op; ld_rd = r; ld_addr = a;
    step();
    ld_valid = 1'b0; mem_valid = 1'b1; mem_data = m;
    step();
    mem_valid = 1'b0;
  endtask

  bit hold;

  initial begin
    #2;
    chk("reset_we", {28'h0, we_le}, 32'h0);
    chk("reset_rd", {27'h0, rd_le}, 32'h0);
    chk("reset_D", d_le, 32'h0);
    chk("reset_load_rd", {27'h0, load_rd_be}, 32'h0);
    chk("reset_ld_ready", {31'h0, ld_ready_le}, 32'h1);
    #10 reset_n = 1'b1;
    step();

    // Reset while a load is outstanding; its late mem_valid must not write.
    ld_valid = 1'b1; ld_op = LD_LW; ld_rd = 5'd5; ld_addr = 2'd0;
    step();
    ld_valid = 1'b0;
    chk("busy_before_reset", {31'h0, load_busy_le}, 32'h1);
    reset_n = 1'b0; #2; reset_n = 1'b1;
    mem_valid = 1'b1; mem_data = 32'h55667788;
    step();
    mem_valid = 1'b0;
    chk("rst_wait_we", {28'h0, we_le}, 32'h0);
    chk("rst_wait_busy", {31'h0, load_busy_le}, 32'h0);
    chk("rst_wait_ld_ready", {31'h0, ld_ready_le}, 32'h1);

    do_load(LD_LB, 5'd7, 2'd1, 32'h123480AB);
    chk("lb_rd", {27'h0, rd_le}, 32'd7);
    chk("lb_we", {28'h0, we_le}, 32'hF);
    chk("lb_D", d_le, 32'hFFFFFF80);
    chk("lb_model", e_d[0], 32'hFFFFFF80);
    do_load(LD_LBU, 5'd7, 2'd1, 32'h123480AB);
    chk("lbu_D", d_le, 32'h00000080);

    do_load(LD_LWL, 5'd8, 2'd1, 32'hAABBCCDD);
    chk("lwl_we", {28'h0, we_le}, 32'hC);
    chk("lwl_D", d_le & 32'hFFFF0000, 32'hCCDD0000);
    chk("lwl_model", e_d[0] & 32'hFFFF0000, 32'hCCDD0000);
    do_load(LD_LWR, 5'd8, 2'd2, 32'hAABBCCDD);
    chk("lwr_we", {28'h0, we_le}, 32'h3);
    chk("lwr_D", d_le & 32'h0000FFFF, 32'h0000AABB);

    do_load(LD_LH, 5'd4, 2'd2, 32'h8001FFFF);
    chk("be_lh_we", {28'h0, we_be}, 32'hF);
    chk("be_lh_D", d_be, 32'hFFFFFFFF);
    do_load(LD_LHU, 5'd4, 2'd0, 32'h8001FFFF);
    chk("be_lhu_D", d_be, 32'h00008001);
    chk("be_lhu_model", e_d[1], 32'h00008001);

    // Load return and ALU result in the same cycle: load first, ALU next.
    ld_valid = 1'b1; ld_op = LD_LW; ld_rd = 5'd9; ld_addr = 2'd0;
    step();
    ld_valid = 1'b0; mem_valid = 1'b1; mem_data = 32'hCAFE0001;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_d = 32'h11;
    #1;
    chk("coll_alu_ready", {31'h0, alu_ready_le}, 32'h0);
    step();
    mem_valid = 1'b0;
    chk("coll_load_rd", {27'h0, rd_le}, 32'd9);
    chk("coll_load_D", d_le, 32'hCAFE0001);
    step();
    alu_valid = 1'b0;
    chk("coll_alu_rd", {27'h0, rd_le}, 32'd3);
    chk("coll_alu_we", {28'h0, we_le}, 32'hF);
    chk("coll_alu_D", d_le, 32'h11);

    alu_valid = 1'b1; alu_rd = 5'd0; alu_d = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    chk("r0_we", {28'h0, we_le}, 32'h0);
    chk("r0_D", d_le, 32'hDEADBEEF);
    mem_valid = 1'b1; mem_data = 32'h12345678;
    step();
    mem_valid = 1'b0;
    chk("spurious_we", {28'h0, we_le}, 32'h0);

    hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        alu_valid = ($urandom_range(0, 1) == 1);
        alu_rd = 5'($urandom_range(0, 31));
        alu_d = $urandom;
      end
      ld_valid = ($urandom_range(0, 2) == 0);
      ld_op = 3'($urandom_range(0, 7));
      ld_rd = 5'($urandom_range(0, 31));
      ld_addr = 2'($urandom_range(0, 3));
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_data = $urandom;
      #1;
      hold = alu_valid && !alu_ready_le;
      step();
    end
    alu_valid = 1'b0; ld_valid = 1'b0; mem_valid = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mips_load_wb.md
Name: mips_load_wb

Overview:
Writeback stage directly upstream of the MIPS I register file; produces its write port (rd, we, D).
Merges two sources:
- ALU results.
- Load data returning from the data memory.
Aligns, sign-extends and byte-masks load data for LB/LBU/LH/LHU/LW/LWL/LWR. LWL/LWR merge into the register through the file's per-byte write enables, with no read-modify-write.
Tracks one outstanding load and exports its destination for the issue-stage interlock.

Parameters:
BIG_ENDIAN, 0, byte-lane order: 0 = little-endian, 1 = big-endian.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered this cycle.
- alu_ready  out  1  ALU result accepted when alu_valid & alu_ready.
- alu_rd  in  5  ALU destination register.
- alu_d  in  32  ALU result.
- ld_valid  in  1  load issued this cycle.
- ld_ready  out  1  load accepted when ld_valid & ld_ready.
- ld_op  in  3  load kind; encoding in package.
- ld_rd  in  5  load destination register.
- ld_addr  in  2  byte address bits [1:0].
- mem_valid  in  1  memory read data valid; one beat per accepted load.
- mem_data  in  32  aligned memory word.
- load_busy  out  1  load outstanding (state WAIT).
- load_rd  out  5  destination of the outstanding load.
- rd  out  5  register-file write address.
- we  out  4  register-file byte write enables.
- D  out  32  register-file write data.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = IDLE.
  - rd = 0, we = 0000, D = 0, load_rd = 0.
  - Any outstanding load is discarded; a later mem_valid for it is ignored.
- States:
  - IDLE: ld_ready = 1. Load handshake → capture ld_op/ld_rd/ld_addr, go to WAIT.
  - WAIT: ld_ready = 0, load_busy = 1. mem_valid → schedule load writeback, go to IDLE.
  - mem_valid while in IDLE is ignored.
- Outputs rd/we/D are registered:
  - Writeback appears the cycle after the ALU handshake or the mem_valid cycle.
  - we = 0000 in every cycle with no write.
- Write-port arbitration:
  - Load data has priority.
  - alu_ready = !(state == WAIT && mem_valid).
  - A stalled ALU result must be held by its producer.
- ALU write: we = 1111, D = alu_d.
- Destination 0: any write with rd == 0 drives we = 0000; rd and D still update.
- Load lane: a = ld_addr for LE; for BE, byte b = 3 - a and halfword = ld_addr[1] inverted.
- Load alignment (m = mem_data):
  - LB: D = sign-extended byte lane. LBU: D = zero-extended byte lane. we = 1111.
  - LH / LHU: halfword selected by ld_addr[1], sign- or zero-extended; we = 1111. ld_addr[0] is ignored (alignment traps are upstream).
  - LW: D = m, we = 1111.
  - LWL (LE): D = m << 8·(3−a), we = 1111 << (3−a) truncated to 4 bits.
  - LWR (LE): D = m >> 8·a, we = 1111 >> a.
  - BE: LWL/LWR swap formulas with a replaced by 3−a.
  - Bytes not enabled: D content is don't-care; the bench checks enabled lanes only.
- Undefined ld_op: treated as LW.
- Back-to-back loads:
  - mem_valid in cycle N → state is IDLE in N+1 → next load accepted in N+1.
  - Throughput is therefore one load per two cycles minimum.
- Interlock:
  - load_busy/load_rd are valid from the cycle after acceptance until the mem_valid cycle inclusive.
  - The issue stage stalls readers of load_rd.

Decomposition:
- Package mips_load_pkg:
  - ld_op encodings: LB = 0, LH = 1, LWL = 2, LW = 3, LBU = 4, LHU = 5, LWR = 6.
  - State encoding.
- Sub-module mips_load_align: purely combinational; (op, addr, data, BIG_ENDIAN) → (we, D).

Test Plan:
- Reset mid-WAIT (load LW, rd = 5 accepted, reset_n pulsed, then mem_valid) → we stays 0000; load_busy = 0; ld_ready = 1.
- LE, LB, a = 1, m = 0x123480AB → next cycle rd = 7, we = 1111, D = 0xFFFFFF80. Same with LBU → D = 0x00000080.
- LE, LWL, a = 1, m = 0xAABBCCDD → we = 1100, D[31:16] = 0xCCDD. LWR, a = 2 → we = 0011, D[15:0] = 0xAABB.
- Collision: WAIT with mem_valid and alu_valid (rd = 3, 0x11) in the same cycle → alu_ready = 0; load written first; ALU write (we = 1111, D = 0x11) appears one cycle later.
- ALU write to rd = 0 with 0xDEADBEEF → we = 0000. Spurious mem_valid in IDLE → no write.
- BE, LH, addr = 2, m = 0x8001FFFF → D = 0xFFFFFFFF; LHU, addr = 0 → D = 0x00008001.
